// File: rtl/nn_io_pkg.sv
// Shared definitions for generated neural-network tops: frame controller
// states, address-width helpers and default frame geometry.
package nn_io_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_N_IN   = 3;
    localparam int DEFAULT_N_OUT  = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_e;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // Address width for a buffer of the given depth, never narrower than 1 bit.
    function automatic int addr_w(input int depth);
        return (clog2(depth) < 1) ? 1 : clog2(depth);
    endfunction

endpackage

// File: rtl/nn_sample_ram.sv
// Small sample buffer: one synchronous write port and one registered read
// port. Reads of the address being written return the new value.
module nn_sample_ram
    import nn_io_pkg::*;
#(
    parameter int DEPTH = DEFAULT_N_IN,
    parameter int WIDTH = DEFAULT_DATA_W,
    localparam int AW   = addr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_d;
    logic [WIDTH-1:0] rdata_q;
    logic             wr_en;
    logic             rd_in_range;

    assign wr_en       = we && (int'(waddr) < DEPTH);
    assign rd_in_range = int'(raddr) < DEPTH;

    // NOTE: the storage array has no reset; only the read register does, so the array can map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = '0;
        if (rd_in_range) begin
            rdata_d = (wr_en && (waddr == raddr)) ? wdata : mem_q[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/nn_frame_io_ctrl.sv
// Frame I/O controller: loads N_IN samples, hands them to the layer pipeline,
// captures N_OUT results and streams them out with backpressure.
module nn_frame_io_ctrl
    import nn_io_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int N_IN    = DEFAULT_N_IN,
    parameter int N_OUT   = DEFAULT_N_OUT,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16,
    localparam int IAW    = addr_w(N_IN),
    localparam int OAW    = addr_w(N_OUT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              core_req,
    input  logic              core_ack,
    input  logic [IAW-1:0]    core_in_addr,
    output logic [DATA_W-1:0] core_in_data,
    input  logic              core_out_we,
    input  logic [OAW-1:0]    core_out_addr,
    input  logic [DATA_W-1:0] core_out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [OAW-1:0]    out_index,
    output logic              out_last,
    output logic              busy,
    output logic              timeout_err,
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam int WD_W = addr_w(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [IAW-1:0]  WR_LAST  = IAW'(N_IN - 1);
    localparam logic [OAW-1:0]  RD_LAST  = OAW'(N_OUT - 1);

    state_e            state_d, state_q;
    logic [IAW-1:0]    wr_cnt_d, wr_cnt_q;
    logic [OAW-1:0]    rd_cnt_d, rd_cnt_q;
    logic [WD_W-1:0]   wd_cnt_d, wd_cnt_q;
    logic              timeout_err_d, timeout_err_q;
    logic [CNT_W-1:0]  frame_cnt_d, frame_cnt_q;

    logic in_fire;
    logic out_fire;
    logic wd_expire;
    logic obuf_we;

    assign in_fire   = in_valid && (state_q == LOAD);
    assign out_fire  = out_ready && (state_q == DRAIN);
    assign wd_expire = (TIMEOUT > 0) && (wd_cnt_q == WD_LAST);
    assign obuf_we   = core_out_we && (state_q == RUN);

    // NOTE: every _d gets its default first so no branch can infer a latch.
    always_comb begin
        state_d       = state_q;
        wr_cnt_d      = wr_cnt_q;
        rd_cnt_d      = rd_cnt_q;
        wd_cnt_d      = '0;
        timeout_err_d = timeout_err_q;
        frame_cnt_d   = frame_cnt_q;

        unique case (state_q)
            IDLE: begin
                state_d = LOAD;
            end
            LOAD: begin
                if (in_fire) begin
                    if (wr_cnt_q == WR_LAST) begin
                        wr_cnt_d = '0;
                        state_d  = RUN;
                    end else begin
                        wr_cnt_d = wr_cnt_q + IAW'(1);
                    end
                end
            end
            RUN: begin
                wd_cnt_d = wd_cnt_q + WD_W'(1);
                // An ack on the expiry cycle completes the frame normally.
                if (core_ack) begin
                    state_d = DRAIN;
                end else if (wd_expire) begin
                    timeout_err_d = 1'b1;
                    state_d       = LOAD;
                end
            end
            DRAIN: begin
                if (out_fire) begin
                    if (rd_cnt_q == RD_LAST) begin
                        rd_cnt_d    = '0;
                        frame_cnt_d = frame_cnt_q + CNT_W'(1);
                        state_d     = LOAD;
                    end else begin
                        rd_cnt_d = rd_cnt_q + OAW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            wr_cnt_q      <= '0;
            rd_cnt_q      <= '0;
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            wr_cnt_q      <= wr_cnt_d;
            rd_cnt_q      <= rd_cnt_d;
            wd_cnt_q      <= wd_cnt_d;
            timeout_err_q <= timeout_err_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    nn_sample_ram #(
        .DEPTH (N_IN),
        .WIDTH (DATA_W)
    ) u_ibuf (
        .clk   (clk),
        .rst   (rst),
        .we    (in_fire),
        .waddr (wr_cnt_q),
        .wdata (in_data),
        .raddr (core_in_addr),
        .rdata (core_in_data)
    );

    // Reading at rd_cnt_d prefetches, so out_data tracks rd_cnt_q with no bubble.
    nn_sample_ram #(
        .DEPTH (N_OUT),
        .WIDTH (DATA_W)
    ) u_obuf (
        .clk   (clk),
        .rst   (rst),
        .we    (obuf_we),
        .waddr (core_out_addr),
        .wdata (core_out_data),
        .raddr (rd_cnt_d),
        .rdata (out_data)
    );

    assign in_ready    = (state_q == LOAD);
    assign core_req    = (state_q == RUN);
    assign out_valid   = (state_q == DRAIN);
    assign out_index   = rd_cnt_q;
    assign out_last    = (state_q == DRAIN) && (rd_cnt_q == RD_LAST);
    assign busy        = (state_q != IDLE);
    assign timeout_err = timeout_err_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_nn_frame_io_ctrl.sv
// Scoreboard bench for nn_frame_io_ctrl (N_IN=3, N_OUT=3, TIMEOUT=16):
// directed frames push expected results; a monitor pops them on out handshakes.
module tb_nn_frame_io_ctrl;

    localparam int DATA_W  = 8;
    localparam int N_IN    = 3;
    localparam int N_OUT   = 3;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 16;
    localparam int IAW     = 2;
    localparam int OAW     = 2;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              core_req;
    logic              core_ack;
    logic [IAW-1:0]    core_in_addr;
    logic [DATA_W-1:0] core_in_data;
    logic              core_out_we;
    logic [OAW-1:0]    core_out_addr;
    logic [DATA_W-1:0] core_out_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [OAW-1:0]    out_index;
    logic              out_last;
    logic              busy;
    logic              timeout_err;
    logic [CNT_W-1:0]  frame_cnt;

    nn_frame_io_ctrl #(
        .DATA_W  (DATA_W),
        .N_IN    (N_IN),
        .N_OUT   (N_OUT),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .core_req      (core_req),
        .core_ack      (core_ack),
        .core_in_addr  (core_in_addr),
        .core_in_data  (core_in_data),
        .core_out_we   (core_out_we),
        .core_out_addr (core_out_addr),
        .core_out_data (core_out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_index     (out_index),
        .out_last      (out_last),
        .busy          (busy),
        .timeout_err   (timeout_err),
        .frame_cnt     (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [OAW-1:0]    idx;
        logic              last;
    } exp_t;

    exp_t exp_q [$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [DATA_W-1:0] d, input logic [OAW-1:0] i, input logic l);
        exp_t e;
        e.data = d;
        e.idx  = i;
        e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops one expected result per output handshake, and checks that
    // a stalled result is held unchanged into the next cycle.
    initial begin
        logic       stall_seen;
        logic [9:0] held;
        exp_t       e;
        stall_seen = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_seen = 1'b0;
            end else begin
                if (stall_seen) check("out_hold", {22'd0, out_index, out_data}, {22'd0, held});
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL out_unexpected: got data 0x%0h idx %0d, expected no output", out_data, out_index);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", 32'(out_data), 32'(e.data));
                        check("out_index", 32'(out_index), 32'(e.idx));
                        check("out_last", 32'(out_last), 32'(e.last));
                    end
                    stall_seen = 1'b0;
                end else if (out_valid) begin
                    stall_seen = 1'b1;
                    held       = {out_index, out_data};
                end else begin
                    stall_seen = 1'b0;
                end
            end
        end
    end

    task automatic load_frame(input logic [DATA_W-1:0] s0, input logic [DATA_W-1:0] s1,
                              input logic [DATA_W-1:0] s2, input int gap);
        logic [DATA_W-1:0] s [3];
        s[0] = s0;
        s[1] = s1;
        s[2] = s2;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b0;
            for (int g = 0; g < gap; g++) begin
                tick();
                check("gap_no_req", 32'(core_req), 32'd0);
                check("gap_still_loading", 32'(in_ready), 32'd1);
            end
            in_valid = 1'b1;
            in_data  = s[k];
            for (int n = 0; n < 20 && !in_ready; n++) tick();
            check("load_in_ready", 32'(in_ready), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        check("req_after_load", 32'(core_req), 32'd1);
        check("ready_after_load", 32'(in_ready), 32'd0);
    endtask

    task automatic core_write(input logic [OAW-1:0] a, input logic [DATA_W-1:0] d, input logic ack);
        core_out_we   = 1'b1;
        core_out_addr = a;
        core_out_data = d;
        core_ack      = ack;
        tick();
        core_out_we = 1'b0;
        core_ack    = 1'b0;
    endtask

    task automatic wait_frame(input int target, input bit toggle);
        for (int c = 0; c < 60 && frame_cnt != CNT_W'(target); c++) begin
            out_ready = toggle ? (c % 3 == 0) : 1'b1;
            tick();
        end
        check("frame_cnt", 32'(frame_cnt), 32'(target));
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        check("valid_after_drain", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [DATA_W-1:0] basic [3];
        logic [IAW-1:0]    rd_addr [4];
        logic [DATA_W-1:0] rd_exp [4];
        int                k;

        basic[0] = 8'd5;  basic[1] = 8'hFD; basic[2] = 8'd7;
        rd_addr[0] = 2'd1; rd_addr[1] = 2'd0; rd_addr[2] = 2'd2; rd_addr[3] = 2'd3;
        rd_exp[0] = 8'hFD; rd_exp[1] = 8'd5;  rd_exp[2] = 8'd7;  rd_exp[3] = 8'd0;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; core_ack = 1'b0; core_in_addr = '0;
        core_out_we = 1'b0; core_out_addr = '0; core_out_data = '0; out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_core_req", 32'(core_req), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_index", 32'(out_index), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_core_in_data", 32'(core_in_data), 32'd0);
        rst = 1'b0;

        // Frame 1: in_valid held high, in_ready must be up for exactly 3 cycles.
        k = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (in_ready) begin
                in_data = (k < 3) ? basic[k] : 8'h00;
                k++;
            end
            tick();
        end
        in_valid = 1'b0;
        check("ready_cycles", 32'(k), 32'd3);
        check("req_first_run", 32'(core_req), 32'd1);
        check("ready_first_run", 32'(in_ready), 32'd0);
        check("busy_run", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            core_in_addr = rd_addr[i];
            tick();
            check("core_in_data", 32'(core_in_data), 32'(rd_exp[i]));
        end
        push_exp(8'd42, 2'd0, 1'b0);
        push_exp(8'd43, 2'd1, 1'b0);
        push_exp(8'd44, 2'd2, 1'b1);
        out_ready = 1'b1;
        core_write(2'd0, 8'd42, 1'b0);
        core_write(2'd1, 8'd43, 1'b0);
        core_write(2'd2, 8'd44, 1'b1);
        check("req_drop_after_ack", 32'(core_req), 32'd0);
        wait_frame(1, 1'b0);

        // Frame 2: gaps between input samples, then output backpressure.
        load_frame(8'd10, 8'hEC, 8'd30, 2);
        core_in_addr = 2'd2;
        tick();
        check("core_in_data_f2", 32'(core_in_data), 32'd30);
        push_exp(8'd1, 2'd0, 1'b0);
        push_exp(8'd2, 2'd1, 1'b0);
        push_exp(8'd3, 2'd2, 1'b1);
        core_write(2'd0, 8'd1, 1'b0);
        core_write(2'd1, 8'd2, 1'b0);
        core_write(2'd2, 8'd3, 1'b1);
        wait_frame(2, 1'b1);

        // Frame 3: no ack, watchdog expires at the end of RUN cycle 16.
        out_ready = 1'b0;
        load_frame(8'd1, 8'd2, 8'd3, 0);
        repeat (15) tick();
        check("wd_req_cycle16", 32'(core_req), 32'd1);
        check("wd_err_cycle16", 32'(timeout_err), 32'd0);
        tick();
        check("wd_err_set", 32'(timeout_err), 32'd1);
        check("wd_req_drop", 32'(core_req), 32'd0);
        check("wd_back_to_load", 32'(in_ready), 32'd1);
        check("wd_frame_cnt", 32'(frame_cnt), 32'd2);
        check("wd_no_drain", 32'(out_valid), 32'd0);
        core_ack = 1'b1;
        tick();
        core_ack = 1'b0;
        check("ack_in_load_ignored", 32'(in_ready), 32'd1);

        // Frame 4: normal frame after a timeout; the flag stays set.
        load_frame(8'd4, 8'd5, 8'd6, 0);
        push_exp(8'd9, 2'd0, 1'b0);
        push_exp(8'd8, 2'd1, 1'b0);
        push_exp(8'd7, 2'd2, 1'b1);
        core_write(2'd0, 8'd9, 1'b0);
        core_write(2'd1, 8'd8, 1'b0);
        core_write(2'd2, 8'd7, 1'b1);
        wait_frame(3, 1'b0);
        check("err_sticky", 32'(timeout_err), 32'd1);

        // Frame 5: reset in the middle of DRAIN.
        out_ready = 1'b0;
        load_frame(8'd7, 8'd7, 8'd7, 0);
        core_write(2'd0, 8'd21, 1'b0);
        core_write(2'd1, 8'd22, 1'b0);
        core_write(2'd2, 8'd23, 1'b1);
        check("drain_valid", 32'(out_valid), 32'd1);
        check("drain_first_data", 32'(out_data), 32'd21);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("mid_rst_timeout_err", 32'(timeout_err), 32'd0);
        check("mid_rst_out_data", 32'(out_data), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);

        // Frame 6: ack on the expiry cycle plus an out-of-range result write.
        load_frame(8'd1, 8'd1, 8'd1, 0);
        core_write(2'd0, 8'd11, 1'b0);
        core_write(2'd1, 8'd12, 1'b0);
        core_write(2'd3, 8'd99, 1'b0);
        core_write(2'd2, 8'd13, 1'b0);
        repeat (11) tick();
        core_ack = 1'b1;
        tick();
        core_ack = 1'b0;
        check("expiry_ack_no_err", 32'(timeout_err), 32'd0);
        check("expiry_ack_drain", 32'(out_valid), 32'd1);
        push_exp(8'd11, 2'd0, 1'b0);
        push_exp(8'd12, 2'd1, 1'b0);
        push_exp(8'd13, 2'd2, 1'b1);
        wait_frame(1, 1'b0);
        check("expiry_err_final", 32'(timeout_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion by 200000");
        $fatal(1, "bench time limit");
    end

endmodule
